serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial add/subtract sequencer that time-shares a single full_adder cell across all bits of a WIDTH-bit operation. One bit is processed per clock and the carry is held in a flop between bits. An input start/busy handshake accepts operands, and an output valid/ready handshake holds the result until it is consumed. It is the area-minimal alternative to the parallel adder stages in the multiplier datapath, and the control template for later serial arithmetic blocks.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 2
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  request; accepted only when o_busy = 0
- i_A  in  WIDTH  operand A, sampled on accepted start
- i_B  in  WIDTH  operand B, sampled on accepted start
- i_sub  in  1  0 = A+B, 1 = A−B; sampled on accepted start
- o_busy  out  1  high in SHIFT and HOLD states
- o_valid  out  1  result available (HOLD state)
- i_ready  in  1  consumer accepts result when o_valid & i_ready
- o_result  out  WIDTH  sum/difference
- o_carry  out  1  final carry out (for subtract: 1 = no borrow)
- o_overflow  out  1  signed two's-complement overflow

## Operation
- FSM states, 2-bit encoding: IDLE=00, SHIFT=01, HOLD=10. Code 11 is illegal and transitions to IDLE.
- IDLE, with i_start:
  - load a_sh ← i_A and b_sh ← i_B ^ {WIDTH{i_sub}};
  - load c ← i_sub and bit counter ← 0;
  - go to SHIFT.
- IDLE, without i_start: stay in IDLE.
- SHIFT, each cycle:
  - full_adder inputs are (a_sh[0], b_sh[0], c);
  - a_sh and b_sh shift right by 1;
  - the sum bit enters acc[WIDTH-1] and acc shifts right;
  - c ← carry;
  - counter increments.
- SHIFT, on the cycle with counter = WIDTH-1:
  - o_result ← final acc (including this bit);
  - o_carry ← carry;
  - o_overflow ← c_in ^ carry, where c_in is the carry into the MSB;
  - go to HOLD.
- HOLD: o_valid = 1. Go to IDLE on o_valid & i_ready.
- o_result, o_carry and o_overflow are dedicated output registers. They update only on HOLD entry and stay stable through HOLD and IDLE until the next completion.
- i_start while o_busy = 1 is ignored. There is no queueing.
- Arithmetic is modulo 2^WIDTH. The counter width is $clog2(WIDTH)+1.

## Timing
- Reset values: state = IDLE; o_busy, o_valid, o_result, o_carry and o_overflow are all 0; internal shift registers, counter and carry flop are 0.
- Reset is asynchronous, so outputs clear without waiting for a clock edge.
- Start accepted at edge k: bits 0..WIDTH-1 are processed at edges k+1..k+WIDTH. o_valid rises after edge k+WIDTH, giving a latency of WIDTH cycles.
- o_busy rises after edge k and falls after the edge where o_valid & i_ready.
- o_valid stays high with o_result stable for as long as i_ready = 0.
- i_start and i_ready both high in HOLD: the result is consumed and the start is ignored. Start is accepted no earlier than the following IDLE cycle, so minimum throughput is one operation per WIDTH+2 cycles.
- Reset asserted mid-SHIFT or mid-HOLD aborts the operation. The result is lost and no o_valid is produced for it.

## Structure
- A shared package holds the state encoding constants (ST_IDLE, ST_SHIFT, ST_HOLD) and the 2-bit state width.
- The datapath instantiates exactly one existing full_adder cell (ports i_A, i_B, i_C, o_sum, o_carry). There is no new sub-module.
- Everything else is FSM, counter and shift registers within serial_adder_ctrl.

## Test plan
All scenarios use WIDTH = 8.
- Add with signed overflow: A=0x5A, B=0x3C, sub=0 → o_valid exactly 8 cycles after start; o_result=0x96, o_carry=0, o_overflow=1.
- Unsigned wrap: A=0xFF, B=0x01, sub=0 → o_result=0x00, o_carry=1, o_overflow=0.
- Subtract:
  - 0x10−0x20 → o_result=0xF0, o_carry=0, o_overflow=0;
  - 0x80−0x01 → o_result=0x7F, o_carry=1, o_overflow=1.
- Backpressure and ignored starts: i_ready held low 5 cycles in HOLD, i_start pulsed during SHIFT and HOLD with other operands → o_valid held, result unchanged, no second operation started.
- Async reset mid-operation: i_rst asserted after 3 SHIFT cycles → all outputs 0 immediately. A new op 0x01+0x02 afterwards → o_result=0x03.
- Back-to-back: i_start and i_ready both high in HOLD → start ignored. Start on the next cycle → accepted, o_busy high, result after 8 cycles.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
// Holds the FSM state width and the state encoding.
package serial_adder_ctrl_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_HOLD  = 2'b10
   } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, shared by serial arithmetic blocks.
module full_adder (
   input  logic i_A,
   input  logic i_B,
   input  logic i_C,
   output logic o_sum,
   output logic o_carry
);

   assign o_sum   = i_A ^ i_B ^ i_C;
   assign o_carry = (i_A & i_B) | (i_A & i_C) | (i_B & i_C);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full_adder reused for every bit, LSB first,
// with a start/busy input handshake and a valid/ready output handshake.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_A,
   input  logic [WIDTH-1:0] i_B,
   input  logic             i_sub,
   output logic             o_busy,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_overflow
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   // Only WIDTH-1 sum bits are buffered; the MSB comes straight from the adder on completion.
   logic [WIDTH-2:0] acc_q, acc_d;
   logic             c_q, c_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;

   logic fa_sum, fa_carry;
   logic last_bit;

   full_adder u_full_adder (
      .i_A     (a_sh_q[0]),
      .i_B     (b_sh_q[0]),
      .i_C     (c_q),
      .o_sum   (fa_sum),
      .o_carry (fa_carry)
   );

   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      acc_d    = acc_q;
      c_d      = c_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               // Subtract as A + ~B + 1: invert B here, inject the +1 as the initial carry.
               a_sh_d  = i_A;
               b_sh_d  = i_B ^ {WIDTH{i_sub}};
               c_d     = i_sub;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            a_sh_d            = a_sh_q >> 1;
            b_sh_d            = b_sh_q >> 1;
            acc_d             = acc_q >> 1;
            acc_d[WIDTH-2]    = fa_sum;
            c_d               = fa_carry;
            cnt_d             = cnt_q + CNT_W'(1);
            if (last_bit) begin
               result_d = {fa_sum, acc_q};
               carry_d  = fa_carry;
               ovf_d    = c_q ^ fa_carry;
               state_d  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (i_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         acc_q    <= '0;
         c_q      <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         acc_q    <= acc_d;
         c_q      <= c_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
      end
   end

   assign o_busy     = (state_q == ST_SHIFT) || (state_q == ST_HOLD);
   assign o_valid    = (state_q == ST_HOLD);
   assign o_result   = result_q;
   assign o_carry    = carry_q;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH = 8): stimulus pushes hand-computed results
// into a queue, a monitor pops and compares on every valid/ready handshake.
module tb_serial_adder_ctrl;

   localparam int unsigned WIDTH = 8;

   logic             i_clk;
   logic             i_rst;
   logic             i_start;
   logic [WIDTH-1:0] i_A;
   logic [WIDTH-1:0] i_B;
   logic             i_sub;
   logic             o_busy;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_result;
   logic             o_carry;
   logic             o_overflow;

   int checks = 0;
   int errors = 0;

   // {result, carry, overflow}
   logic [WIDTH+1:0] exp_q[$];

   serial_adder_ctrl #(
      .WIDTH (WIDTH)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_start    (i_start),
      .i_A        (i_A),
      .i_B        (i_B),
      .i_sub      (i_sub),
      .o_busy     (o_busy),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_result   (o_result),
      .o_carry    (o_carry),
      .o_overflow (o_overflow)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every consumed result must match the oldest outstanding expectation.
   always @(posedge i_clk) begin
      if (!i_rst && o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got 0x%0h with no operation outstanding", o_result);
         end else begin
            logic [WIDTH+1:0] e;
            e = exp_q.pop_front();
            chk("result", 32'(o_result), 32'(e[WIDTH+1:2]));
            chk("carry", 32'(o_carry), 32'(e[1]));
            chk("overflow", 32'(o_overflow), 32'(e[0]));
         end
      end
   end

   // Call at a negedge: present operands, record expected response.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic [7:0] er, input logic ec, input logic eo);
      i_start = 1'b1;
      i_A     = a;
      i_B     = b;
      i_sub   = sub;
      exp_q.push_back({er, ec, eo});
   endtask

   // Wait for o_valid after a start; optionally pulse a bogus start at negedge index pulse_at.
   task automatic wait_valid(input int pulse_at, input string tag);
      int lat;
      lat = -1;
      for (int j = 0; j <= 40; j++) begin
         @(negedge i_clk);
         if (j == 0) begin
            i_start = 1'b0;
            chk({tag, "_busy_after_start"}, 32'(o_busy), 32'd1);
         end
         if (pulse_at >= 0 && j == pulse_at) begin
            i_start = 1'b1;
            i_A     = 8'hAA;
            i_B     = 8'h55;
            i_sub   = 1'b1;
         end else if (pulse_at >= 0 && j == pulse_at + 1) begin
            i_start = 1'b0;
         end
         if (o_valid) begin
            lat = j;
            break;
         end
      end
      i_start = 1'b0;
      chk({tag, "_latency"}, 32'(lat), 32'd8);
   endtask

   task automatic consume(input string tag);
      i_ready = 1'b1;
      @(negedge i_clk);
      i_ready = 1'b0;
      chk({tag, "_valid_after_ready"}, 32'(o_valid), 32'd0);
      chk({tag, "_busy_after_ready"}, 32'(o_busy), 32'd0);
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input logic [7:0] er, input logic ec, input logic eo, input string tag);
      @(negedge i_clk);
      issue(a, b, sub, er, ec, eo);
      wait_valid(-1, tag);
      consume(tag);
   endtask

   initial begin
      int seen;
      i_rst   = 1'b1;
      i_start = 1'b0;
      i_A     = '0;
      i_B     = '0;
      i_sub   = 1'b0;
      i_ready = 1'b0;
      #1;
      chk("reset_busy", 32'(o_busy), 32'd0);
      chk("reset_valid", 32'(o_valid), 32'd0);
      chk("reset_result", 32'(o_result), 32'd0);
      chk("reset_carry", 32'(o_carry), 32'd0);
      chk("reset_overflow", 32'(o_overflow), 32'd0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;

      run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "add_ovf");
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "wrap");
      run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_borrow");
      run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf");

      // Async reset three bits into an operation: outputs clear without a clock edge.
      @(negedge i_clk);
      issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
      for (int j = 0; j <= 3; j++) begin
         @(negedge i_clk);
         if (j == 0) i_start = 1'b0;
      end
      #2;
      i_rst = 1'b1;
      void'(exp_q.pop_back());
      #1;
      chk("rst_mid_busy", 32'(o_busy), 32'd0);
      chk("rst_mid_valid", 32'(o_valid), 32'd0);
      chk("rst_mid_result", 32'(o_result), 32'd0);
      chk("rst_mid_carry", 32'(o_carry), 32'd0);
      chk("rst_mid_overflow", 32'(o_overflow), 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      seen = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge i_clk);
         if (o_valid || o_busy) seen++;
      end
      chk("rst_no_valid", 32'(seen), 32'd0);
      run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after_rst");

      // Backpressure with starts pulsed in SHIFT and HOLD.
      @(negedge i_clk);
      issue(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0);
      wait_valid(3, "bp");
      for (int j = 0; j < 5; j++) begin
         chk("bp_valid_held", 32'(o_valid), 32'd1);
         chk("bp_result_held", 32'(o_result), 32'h77);
         if (j == 2) begin
            i_start = 1'b1;
            i_A     = 8'h01;
            i_B     = 8'h01;
            i_sub   = 1'b0;
         end else begin
            i_start = 1'b0;
         end
         @(negedge i_clk);
      end
      i_start = 1'b0;
      consume("bp");
      seen = 0;
      for (int j = 0; j < 10; j++) begin
         @(negedge i_clk);
         if (o_valid || o_busy) seen++;
      end
      chk("bp_no_second_op", 32'(seen), 32'd0);

      // Back-to-back: start alongside ready in HOLD is dropped, next-cycle start is taken.
      @(negedge i_clk);
      issue(8'h20, 8'h30, 1'b0, 8'h50, 1'b0, 1'b0);
      wait_valid(-1, "b2b_first");
      i_ready = 1'b1;
      i_start = 1'b1;
      i_A     = 8'hC3;
      i_B     = 8'h11;
      i_sub   = 1'b1;
      @(negedge i_clk);
      i_ready = 1'b0;
      chk("b2b_idle_valid", 32'(o_valid), 32'd0);
      chk("b2b_idle_busy", 32'(o_busy), 32'd0);
      issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      wait_valid(-1, "b2b_second");
      consume("b2b_second");

      repeat (3) @(negedge i_clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
